raw_line_read_sched: RTL and testbench

Read scheduler for the Bayer-to-RGB path. It derives the line-buffer read strobe and the pixel/line counters from the VGA sync timing, and gates the demosaic enable to the valid column window. It replaces the free-running request logic in front of the two-line buffer and the 2x2 Bayer interpolator, and adds frame sequencing, enable control and sync-error detection.

---
 rtl/raw_line_read_sched_pkg.sv | 15 +
 rtl/raw_line_read_sched_sync_edge_det.sv | 22 ++
 rtl/raw_line_read_sched.sv | 162 ++++++++++++++++
 tb/tb_raw_line_read_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raw_line_read_sched_pkg.sv
// rtl/raw_line_read_sched_pkg.sv - shared state encoding and counter width for the Bayer read scheduler
package raw_line_read_sched_pkg;

    localparam int CNT_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        VBP,
        HBP,
        ACTIVE,
        HBLANK
    } schedStateT;

endpackage

// File: rtl/raw_line_read_sched_sync_edge_det.sv
// rtl/raw_line_read_sched_sync_edge_det.sv - sync input register plus registered rising-edge pulse
module sync_edge_det (
    input  logic VGA_CLK,
    input  logic RESET_N,
    input  logic syncIn,
    output logic rise
);

    logic syncReg;

    // Syncs idle high, so the register resets high to avoid a false edge after reset release.
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            syncReg <= 1'b1;
            rise    <= 1'b0;
        end else begin
            syncReg <= syncIn;
            rise    <= syncIn & ~syncReg;
        end
    end

endmodule

// File: rtl/raw_line_read_sched.sv
// rtl/raw_line_read_sched.sv - line-buffer read strobe, pixel/line counters and demosaic window from VGA sync
module raw_line_read_sched
    import raw_line_read_sched_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BP     = 48,
    parameter int V_BP     = 33,
    parameter int VAL_MIN  = 3,
    parameter int VAL_MAX  = 637
) (
    input  logic             VGA_CLK,
    input  logic             RESET_N,
    input  logic             VGA_VS,
    input  logic             VGA_HS,
    input  logic             EN,
    output logic             READ_Request,
    output logic [CNT_W-1:0] X_Cont,
    output logic [CNT_W-1:0] Y_Cont,
    output logic             RD_EN,
    output logic             FRAME_START,
    output logic             SYNC_ERR,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_END    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HBP_LAST = CNT_W'(H_BP - 1);
    localparam logic [CNT_W-1:0] VBP_LAST = CNT_W'(V_BP - 1);
    localparam logic [CNT_W-1:0] X_LO     = CNT_W'(VAL_MIN);
    localparam logic [CNT_W-1:0] X_HI     = CNT_W'(VAL_MAX);

    schedStateT       state;
    logic [CNT_W-1:0] hbpCnt;
    logic [CNT_W-1:0] vbpCnt;
    logic             vsRise;
    logic             hsRise;

    sync_edge_det vsDet (
        .VGA_CLK (VGA_CLK),
        .RESET_N (RESET_N),
        .syncIn  (VGA_VS),
        .rise    (vsRise)
    );

    sync_edge_det hsDet (
        .VGA_CLK (VGA_CLK),
        .RESET_N (RESET_N),
        .syncIn  (VGA_HS),
        .rise    (hsRise)
    );

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            READ_Request <= 1'b0;
            X_Cont       <= '0;
            Y_Cont       <= '0;
            FRAME_START  <= 1'b0;
            SYNC_ERR     <= 1'b0;
            BUSY         <= 1'b0;
            hbpCnt       <= '0;
            vbpCnt       <= '0;
        end else begin
            FRAME_START <= 1'b0;
            // A VS edge inside a running frame outranks everything, including a same-cycle HS edge.
            if (vsRise && (state inside {VBP, HBP, ACTIVE, HBLANK})) begin
                state        <= VBP;
                SYNC_ERR     <= 1'b1;
                vbpCnt       <= '0;
                Y_Cont       <= '0;
                X_Cont       <= '0;
                READ_Request <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (EN) begin
                            state <= WAIT_VS;
                            BUSY  <= 1'b1;
                        end
                    end
                    WAIT_VS: begin
                        if (vsRise) begin
                            state  <= VBP;
                            vbpCnt <= '0;
                            Y_Cont <= '0;
                            X_Cont <= '0;
                        end
                    end
                    VBP: begin
                        // The last back-porch HS edge doubles as the line-0 HS.
                        if (hsRise) begin
                            if (vbpCnt == VBP_LAST) begin
                                state  <= HBP;
                                hbpCnt <= CNT_W'(1);
                                X_Cont <= '0;
                            end else begin
                                vbpCnt <= vbpCnt + 1'b1;
                            end
                        end
                    end
                    HBP: begin
                        if (hsRise) begin
                            SYNC_ERR <= 1'b1;
                            hbpCnt   <= CNT_W'(1);
                        end else if (hbpCnt == HBP_LAST) begin
                            state        <= ACTIVE;
                            READ_Request <= 1'b1;
                            if (Y_Cont == '0) begin
                                FRAME_START <= 1'b1;
                                SYNC_ERR    <= 1'b0;
                            end
                        end else begin
                            hbpCnt <= hbpCnt + 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (hsRise) begin
                            state        <= HBP;
                            hbpCnt       <= CNT_W'(1);
                            X_Cont       <= '0;
                            READ_Request <= 1'b0;
                            SYNC_ERR     <= 1'b1;
                        end else begin
                            X_Cont <= X_Cont + 1'b1;
                            if (X_Cont == X_LAST) begin
                                state        <= HBLANK;
                                READ_Request <= 1'b0;
                                Y_Cont       <= Y_Cont + 1'b1;
                            end
                        end
                    end
                    HBLANK: begin
                        if (!EN || (hsRise && (Y_Cont >= Y_END))) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else if (hsRise) begin
                            state  <= HBP;
                            hbpCnt <= CNT_W'(1);
                            X_Cont <= '0;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        BUSY         <= 1'b0;
                        READ_Request <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Window uses the previous cycle's column, so RD_EN trails X_Cont by one.
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RD_EN <= 1'b0;
        end else begin
            RD_EN <= (X_Cont > X_LO) && (X_Cont < X_HI);
        end
    end

endmodule

// File: tb/tb_raw_line_read_sched.sv
// tb/tb_raw_line_read_sched.sv - directed self-checking bench for raw_line_read_sched
module tb_raw_line_read_sched;

    localparam int H_ACTIVE = 24;
    localparam int V_ACTIVE = 5;
    localparam int H_BP     = 6;
    localparam int V_BP     = 3;
    localparam int VAL_MIN  = 3;
    localparam int VAL_MAX  = 21;
    localparam int HS_LOW   = 4;
    localparam int LINE_LEN = 40;

    logic        VGA_CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        VGA_VS  = 1'b1;
    logic        VGA_HS  = 1'b1;
    logic        EN      = 1'b0;
    logic        READ_Request;
    logic [10:0] X_Cont;
    logic [10:0] Y_Cont;
    logic        RD_EN;
    logic        FRAME_START;
    logic        SYNC_ERR;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    int   cyc         = 0;
    int   reqTotal    = 0;
    int   rdTotal     = 0;
    int   fsTotal     = 0;
    int   firstReqCyc = 0;
    int   fsCyc       = 0;
    int   rdRiseX     = 0;
    logic reqPrev     = 1'b0;
    logic rdPrev      = 1'b0;

    int hsRiseCyc = 0;
    int r0;
    int d0;
    int f0;
    int line0Rise;

    raw_line_read_sched #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BP     (H_BP),
        .V_BP     (V_BP),
        .VAL_MIN  (VAL_MIN),
        .VAL_MAX  (VAL_MAX)
    ) dut (
        .VGA_CLK      (VGA_CLK),
        .RESET_N      (RESET_N),
        .VGA_VS       (VGA_VS),
        .VGA_HS       (VGA_HS),
        .EN           (EN),
        .READ_Request (READ_Request),
        .X_Cont       (X_Cont),
        .Y_Cont       (Y_Cont),
        .RD_EN        (RD_EN),
        .FRAME_START  (FRAME_START),
        .SYNC_ERR     (SYNC_ERR),
        .BUSY         (BUSY)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    always @(negedge VGA_CLK) begin
        cyc     <= cyc + 1;
        reqPrev <= READ_Request;
        rdPrev  <= RD_EN;
        if (READ_Request) reqTotal <= reqTotal + 1;
        if (RD_EN) rdTotal <= rdTotal + 1;
        if (READ_Request && !reqPrev) firstReqCyc <= cyc;
        if (RD_EN && !rdPrev) rdRiseX <= int'(X_Cont);
        if (FRAME_START) begin
            fsTotal <= fsTotal + 1;
            fsCyc   <= cyc;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge VGA_CLK);
            #1;
        end
    endtask

    task automatic hsEdge();
        VGA_HS = 1'b0;
        tick(HS_LOW);
        VGA_HS    = 1'b1;
        hsRiseCyc = cyc;
    endtask

    task automatic line();
        hsEdge();
        tick(LINE_LEN - HS_LOW);
    endtask

    task automatic vsPulse();
        VGA_VS = 1'b0;
        tick(10);
        VGA_VS = 1'b1;
        tick(10);
    endtask

    initial begin
        tick(3);
        check("rst_req", READ_Request, 0);
        check("rst_x", X_Cont, 0);
        check("rst_y", Y_Cont, 0);
        check("rst_rden", RD_EN, 0);
        check("rst_fs", FRAME_START, 0);
        check("rst_err", SYNC_ERR, 0);
        check("rst_busy", BUSY, 0);
        RESET_N = 1'b1;
        tick(2);
        check("idle_busy", BUSY, 0);
        EN = 1'b1;
        tick(2);
        check("armed_busy", BUSY, 1);

        // Nominal frame
        vsPulse();
        line();
        line();
        check("vbp_no_req", reqTotal, 0);
        f0 = fsTotal;
        line0Rise = 0;
        for (int i = 0; i < V_ACTIVE; i++) begin
            r0 = reqTotal;
            d0 = rdTotal;
            line();
            if (i == 0) line0Rise = hsRiseCyc;
            check("line_req", reqTotal - r0, H_ACTIVE);
            check("line_rden", rdTotal - d0, VAL_MAX - VAL_MIN - 1);
            check("line_y", Y_Cont, i + 1);
            check("line_x_hold", X_Cont, H_ACTIVE);
            check("line_lat", firstReqCyc - hsRiseCyc, H_BP + 1);
            check("rden_rise_x", rdRiseX, VAL_MIN + 2);
        end
        check("fs_count", fsTotal - f0, 1);
        check("fs_lat", fsCyc - line0Rise, H_BP + 1);
        r0 = reqTotal;
        line();
        check("eof_quiet", reqTotal - r0, 0);
        check("eof_y", Y_Cont, V_ACTIVE);
        check("eof_rearm", BUSY, 1);
        check("eof_err", SYNC_ERR, 0);

        // EN dropped mid-line 2
        vsPulse();
        line();
        line();
        line();
        line();
        r0 = reqTotal;
        hsEdge();
        tick(15);
        EN = 1'b0;
        tick(LINE_LEN - HS_LOW - 15);
        check("enoff_req", reqTotal - r0, H_ACTIVE);
        check("enoff_busy", BUSY, 0);
        check("enoff_y", Y_Cont, 3);
        r0 = reqTotal;
        line();
        line();
        check("enoff_quiet", reqTotal - r0, 0);

        // HS edge mid-ACTIVE at X_Cont=10
        EN = 1'b1;
        tick(2);
        vsPulse();
        line();
        line();
        line();
        hsEdge();
        tick(12);
        VGA_HS = 1'b0;
        tick(HS_LOW);
        VGA_HS = 1'b1;
        tick(1);
        check("abort_x", X_Cont, 10);
        check("abort_req_pre", READ_Request, 1);
        tick(1);
        check("abort_req", READ_Request, 0);
        check("abort_err", SYNC_ERR, 1);
        check("abort_x0", X_Cont, 0);
        check("abort_y", Y_Cont, 1);
        r0 = reqTotal;
        tick(32);
        check("abort_reline", reqTotal - r0, H_ACTIVE);
        check("abort_y2", Y_Cont, 2);

        // VS inside a frame restarts it; FRAME_START clears SYNC_ERR
        vsPulse();
        check("vsr_y", Y_Cont, 0);
        check("vsr_err", SYNC_ERR, 1);
        f0 = fsTotal;
        line();
        line();
        line();
        check("vsr_fs", fsTotal - f0, 1);
        check("vsr_fs_lat", fsCyc - hsRiseCyc, H_BP + 1);
        check("vsr_err_clr", SYNC_ERR, 0);
        line();
        check("vsr_y2", Y_Cont, 2);
        vsPulse();
        check("vs2_err", SYNC_ERR, 1);
        check("vs2_y", Y_Cont, 0);
        check("vs2_busy", BUSY, 1);
        r0 = reqTotal;
        f0 = fsTotal;
        line();
        line();
        check("vs2_vbp", reqTotal - r0, 0);
        line();
        check("vs2_fs", fsTotal - f0, 1);
        check("vs2_fs_lat", fsCyc - hsRiseCyc, H_BP + 1);
        check("vs2_err_clr", SYNC_ERR, 0);

        // VS and HS rising in the same cycle during HBLANK
        VGA_VS = 1'b0;
        VGA_HS = 1'b0;
        tick(HS_LOW);
        VGA_VS = 1'b1;
        VGA_HS = 1'b1;
        tick(2);
        check("both_err", SYNC_ERR, 1);
        check("both_y", Y_Cont, 0);
        check("both_busy", BUSY, 1);
        r0 = reqTotal;
        tick(20);
        line();
        line();
        check("both_vbp", reqTotal - r0, 0);
        line();
        check("both_line0", reqTotal - r0, H_ACTIVE);

        // Async reset mid-line at X_Cont=15
        hsEdge();
        tick(H_BP + 1 + 15);
        check("prerst_x", X_Cont, 15);
        check("prerst_req", READ_Request, 1);
        RESET_N = 1'b0;
        #1;
        check("arst_req", READ_Request, 0);
        check("arst_x", X_Cont, 0);
        check("arst_y", Y_Cont, 0);
        check("arst_rden", RD_EN, 0);
        check("arst_fs", FRAME_START, 0);
        check("arst_busy", BUSY, 0);
        tick(2);
        RESET_N = 1'b1;
        tick(1);
        check("post_rst_busy", BUSY, 1);
        r0 = reqTotal;
        line();
        line();
        line();
        line();
        check("post_rst_quiet", reqTotal - r0, 0);
        vsPulse();
        line();
        line();
        check("post_rst_vbp", reqTotal - r0, 0);
        line();
        check("post_rst_line0", reqTotal - r0, H_ACTIVE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
